// File: rtl/button_repeater_if.sv
// Button event bundle: the debounced level in, and the registered event pulses/level out.
`timescale 1ns/1ps

interface button_repeater_if;
  logic level_in;
  logic press_out;
  logic release_out;
  logic hold_out;
  logic repeat_out;
  logic held_out;

  // master: the consumer that supplies the button level and watches events
  modport master (
    output level_in,
    input  press_out, release_out, hold_out, repeat_out, held_out
  );

  // slave: the repeater itself
  modport slave (
    input  level_in,
    output press_out, release_out, hold_out, repeat_out, held_out
  );
endinterface

// File: rtl/button_repeater.sv
// Press/release/hold/auto-repeat event generator for a debounced button level.
// Define BUTTON_AUTOREPEAT_EN to enable periodic repeat_out pulses while held.
`timescale 1ns/1ps

module button_repeater #(
  parameter real CLK_PERIOD_NS  = 13.47,
  parameter int  HOLD_TIME_MS   = 500,
  parameter int  REPEAT_TIME_MS = 100
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  button_repeater_if.slave  btn
);

  localparam int HOLD_CYCLES   = int'($ceil(real'(HOLD_TIME_MS)   * 1.0e6 / CLK_PERIOD_NS));
  localparam int REPEAT_CYCLES = int'($ceil(real'(REPEAT_TIME_MS) * 1.0e6 / CLK_PERIOD_NS));
  localparam int MAX_CYCLES    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W         = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYCLES);
`endif

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("button_repeater: HOLD_CYCLES and REPEAT_CYCLES must both be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             hold_q, hold_d;
  logic             held_q;
`ifdef BUTTON_AUTOREPEAT_EN
  logic             repeat_q, repeat_d;
`endif

  // Reset release is two-staged: run_q is the first stage and the state
  // register is the second, so the second rising edge after deassertion is
  // the first one that can act on level_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    repeat_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (btn.level_in) begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_ONE;
          press_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn.level_in) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == HOLD_MAX) begin
          state_d = ST_HELD;
          cnt_d   = CNT_ONE;
          hold_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        // Release is tested first so it wins over a coinciding repeat.
        if (!btn.level_in) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (cnt_q == REPEAT_MAX) begin
          cnt_d    = CNT_ONE;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else if (run_q) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      held_q    <= (state_d == ST_HELD);
`ifdef BUTTON_AUTOREPEAT_EN
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign btn.press_out   = press_q;
  assign btn.release_out = release_q;
  assign btn.hold_out    = hold_q;
  assign btn.held_out    = held_q;
`ifdef BUTTON_AUTOREPEAT_EN
  assign btn.repeat_out  = repeat_q;
`else
  assign btn.repeat_out  = 1'b0;
`endif

endmodule

// File: tb/tb_button_repeater.sv
// Scoreboard bench for button_repeater with HOLD_CYCLES=5, REPEAT_CYCLES=2.
`timescale 1ns/1ps

module tb_button_repeater;

  localparam logic [3:0] EV_PRESS   = 4'b1000;
  localparam logic [3:0] EV_RELEASE = 4'b0100;
  localparam logic [3:0] EV_HOLD    = 4'b0010;
  localparam logic [3:0] EV_REPEAT  = 4'b0001;

  typedef struct {
    logic [3:0] pulses;
    int         cycle;
    logic       held;
  } exp_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t sb_q[$];

  button_repeater_if bif ();

  button_repeater #(
    .CLK_PERIOD_NS (1000000.0),
    .HOLD_TIME_MS  (5),
    .REPEAT_TIME_MS(2)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .btn     (bif)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] p, input int c);
    exp_t e;
    e.pulses = p;
    e.cycle  = c;
    e.held   = (p == EV_HOLD) || (p == EV_REPEAT);
    sb_q.push_back(e);
  endtask

  // Hold level_in for n rising edges, returning just after the last one.
  task automatic drive(input logic lvl, input int n);
    bif.level_in = lvl;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Monitor: every cycle with an event pulse consumes one expected entry.
  always @(negedge clk_in) begin
    logic [3:0] pulses;
    exp_t       e;
    pulses = {bif.press_out, bif.release_out, bif.hold_out, bif.repeat_out};
    if (pulses !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'(pulses), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind",  32'(pulses),       32'(e.pulses));
        check("pulse_cycle", 32'(cyc),          32'(e.cycle));
        check("held_level",  32'(bif.held_out), 32'(e.held));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    bif.level_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs",
          32'({bif.press_out, bif.release_out, bif.hold_out, bif.repeat_out, bif.held_out}), 32'd0);
    rst_n_in = 1'b1;
    drive(1'b0, 4);

    // Short tap: three pressed edges.
    e = cyc + 1;
    push(EV_PRESS, e);
    push(EV_RELEASE, e + 3);
    drive(1'b1, 3);
    drive(1'b0, 3);

    // Long hold: twelve pressed edges.
    e = cyc + 1;
    push(EV_PRESS, e);
    push(EV_HOLD, e + 5);
`ifdef BUTTON_AUTOREPEAT_EN
    push(EV_REPEAT, e + 7);
    push(EV_REPEAT, e + 9);
    push(EV_REPEAT, e + 11);
`endif
    push(EV_RELEASE, e + 12);
    drive(1'b1, 12);
    check("held_during_hold", 32'(bif.held_out), 32'd1);
    drive(1'b0, 1);
    check("held_after_release", 32'(bif.held_out), 32'd0);
    drive(1'b0, 2);

    // Release on the hold threshold edge: no hold.
    e = cyc + 1;
    push(EV_PRESS, e);
    push(EV_RELEASE, e + 5);
    drive(1'b1, 5);
    drive(1'b0, 3);

    // Release on the first repeat threshold edge: no repeat.
    e = cyc + 1;
    push(EV_PRESS, e);
    push(EV_HOLD, e + 5);
    push(EV_RELEASE, e + 7);
    drive(1'b1, 7);
    drive(1'b0, 3);

    // Back-to-back: press again on the edge right after release.
    e = cyc + 1;
    push(EV_PRESS, e);
    push(EV_RELEASE, e + 2);
    push(EV_PRESS, e + 3);
    push(EV_RELEASE, e + 5);
    drive(1'b1, 2);
    drive(1'b0, 1);
    drive(1'b1, 2);
    drive(1'b0, 3);

    // Reset while held, button kept pressed through and after reset.
    e = cyc + 1;
    push(EV_PRESS, e);
    push(EV_HOLD, e + 5);
    drive(1'b1, 7);
    check("held_before_reset", 32'(bif.held_out), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({bif.press_out, bif.release_out, bif.hold_out, bif.repeat_out, bif.held_out}), 32'd0);
    drive(1'b1, 3);
    rst_n_in = 1'b1;
    e = cyc + 2;
    push(EV_PRESS, e);
    push(EV_HOLD, e + 5);
`ifdef BUTTON_AUTOREPEAT_EN
    push(EV_REPEAT, e + 7);
`endif
    push(EV_RELEASE, e + 8);
    drive(1'b1, 9);
    drive(1'b0, 3);

    drive(1'b0, 5);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_repeater.md
BUTTON_REPEATER -- requirements
Module: button_repeater

Interface
REQ-001 Parameter CLK_PERIOD_NS, default 13.47, clock period in ns.
REQ-002 Parameter HOLD_TIME_MS, default 500, press duration before hold is declared.
REQ-003 Parameter REPEAT_TIME_MS, default 100, auto-repeat period while held.
REQ-004 Derived HOLD_CYCLES = ceil(HOLD_TIME_MS*1e6/CLK_PERIOD_NS); REPEAT_CYCLES likewise; both SHALL be >=1, otherwise elaboration fails.
REQ-005 Derived counter width = $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1).
REQ-006 clk_in  input  1  sole clock, rising edge.
REQ-007 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-008 level_in  input  1  debounced, synchronous button level; 1 = pressed.
REQ-009 press_out  output  1  one-cycle pulse on press.
REQ-010 release_out  output  1  one-cycle pulse on release.
REQ-011 hold_out  output  1  one-cycle pulse when press reaches HOLD_CYCLES.
REQ-012 repeat_out  output  1  one-cycle pulse every REPEAT_CYCLES after hold.
REQ-013 held_out  output  1  level, high while in HELD state.

Function
REQ-014 All outputs SHALL be registered; no combinational path from level_in to any output.
REQ-015 FSM states: IDLE, PRESSED, HELD.
REQ-016 Edge E = first clock edge sampling level_in=1 while in IDLE; at E: state->PRESSED, counter->1, press_out=1 for the following cycle.
REQ-017 PRESSED: each edge sampling level_in=1 increments counter; at the edge where counter==HOLD_CYCLES and level_in=1 (edge E+HOLD_CYCLES): state->HELD, counter->1, hold_out=1 for one cycle.
REQ-018 HELD: counter increments per edge with level_in=1; when counter==REPEAT_CYCLES, repeat_out pulses one cycle and counter->1; first repeat at edge E+HOLD_CYCLES+REPEAT_CYCLES.
REQ-019 Any edge sampling level_in=0 in PRESSED or HELD: state->IDLE, counter->0, release_out=1 for one cycle, held_out->0.
REQ-020 Release coinciding with hold or repeat threshold: release wins; hold_out/repeat_out SHALL NOT pulse.
REQ-021 At most one of press_out, release_out, hold_out, repeat_out high in any cycle.
REQ-022 Counter SHALL never exceed its threshold; no wrap past width.
REQ-023 Press after release: level_in=1 at the edge immediately after the release edge SHALL produce a new press_out (no dead time).
REQ-024 held_out = 1 exactly while state==HELD.

Reset
REQ-025 rst_n_in low asynchronously forces state IDLE, counter 0, all outputs 0.
REQ-026 Reset deassertion is synchronized to clk_in internally (two-flop release); first functional edge is the second rising edge after deassertion.
REQ-027 Reset mid-press: button still pressed after reset SHALL yield press_out at the first functional edge (fresh press, not resumed hold).

Configuration
REQ-028 Macro BUTTON_AUTOREPEAT_EN: defined -> REQ-018 behaviour; undefined -> repeat_out tied 0, HELD state persists without counting until release, repeat counter logic absent.

Verification
(all with CLK_PERIOD_NS=1000000, HOLD_TIME_MS=5, REPEAT_TIME_MS=2 -> HOLD_CYCLES=5, REPEAT_CYCLES=2)
REQ-029 Short tap: level_in=1 for 3 edges then 0 -> press_out once, release_out once 3 cycles later, no hold_out, held_out stays 0.
REQ-030 Long hold, 12 edges: press_out at E+1 cycle, hold_out after E+5, repeat_out after E+7, E+9, E+11 (autorepeat on); release_out after first 0 edge.
REQ-031 Boundary: level_in drops at exactly edge E+5 -> release_out only, hold_out never asserted.
REQ-032 Back-to-back: release edge followed immediately by press edge -> release_out and press_out in consecutive cycles.
REQ-033 Reset mid-HELD with level_in held 1 -> outputs 0 immediately on rst_n_in low; after release, press_out at first functional edge, hold_out 5 cycles later.
REQ-034 BUTTON_AUTOREPEAT_EN undefined, 12-edge hold -> hold_out once, repeat_out never, held_out high until release.
